intersection_sched: RTL and testbench
=====================================

# intersection_sched

Phase scheduler for the highway/farm-road intersection. Owns the shared phase timer and sequences both roads through green, yellow and all-red clearance, so the two lights never show non-red at the same time. Latches farm-road car requests and grants the farm road a bounded green window. The highway is the default-green road; the farm road is served only on demand.

## Interface
- `SHORT_CYC`, default 3: yellow duration in cycles; ≥1.
- `LONG_CYC`, default 10: minimum highway green and maximum farm green in cycles; ≥2.
- `CLEAR_CYC`, default 2: all-red clearance in cycles; ≥1.
- `FW_MIN_CYC`, default 4: minimum farm green in cycles; 1 ≤ FW_MIN_CYC ≤ LONG_CYC.

Ports:
- `clk`  in  1: sole clock; all state changes on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `car_on_fw`  in  1: farm-road vehicle sensor, level.
- `hw_light`  out  2: highway lamp (RED/GREEN/YELLOW).
- `fw_light`  out  2: farm-road lamp.
- `short_timeout`  out  1: high while timer == SHORT_CYC-1.
- `long_timeout`  out  1: high while timer == LONG_CYC-1.
- `timer_reset`  out  1: Mealy; high in any cycle where a phase transition is taken.
- `fw_req`  out  1: latched farm request, visible for debug.

## Operation
- States: HW_GREEN, HW_YELLOW, CLEAR_TO_FW, FW_GREEN, FW_YELLOW, CLEAR_TO_HW.
- Lamp decode from state only:
  - HW_GREEN: hw = GREEN, fw = RED.
  - HW_YELLOW: hw = YELLOW, fw = RED.
  - FW_GREEN: hw = RED, fw = GREEN.
  - FW_YELLOW: hw = RED, fw = YELLOW.
  - Both CLEAR states: both lamps RED.
- Timer: clears to 0 on every transition. Otherwise increments, saturating at max(LONG_CYC, SHORT_CYC, CLEAR_CYC)-1. Width is $clog2 of that value plus 1.
- `fw_req`:
  - Set when car_on_fw=1 in any state except FW_GREEN.
  - Cleared on entry to FW_GREEN.
  - When set and clear coincide, clear wins.
- Transitions:
  - HW_GREEN→HW_YELLOW: timer == LONG_CYC-1 and (fw_req or car_on_fw).
  - HW_YELLOW→CLEAR_TO_FW: timer == SHORT_CYC-1.
  - CLEAR_TO_FW→FW_GREEN: timer == CLEAR_CYC-1.
  - FW_GREEN→FW_YELLOW: (timer ≥ FW_MIN_CYC-1 and car_on_fw=0) or timer == LONG_CYC-1.
  - FW_YELLOW→CLEAR_TO_HW: timer == SHORT_CYC-1.
  - CLEAR_TO_HW→HW_GREEN: timer == CLEAR_CYC-1.
- Illegal state encoding: go to CLEAR_TO_HW with timer 0; lamps show all RED.
- Safety invariant: hw_light ≠ RED and fw_light ≠ RED never hold in the same cycle.

## Timing
- Reset values (cycle after reset_n sampled low):
  - state HW_GREEN, timer 0, fw_req 0.
  - hw_light GREEN, fw_light RED.
  - short_timeout 0, long_timeout 0, timer_reset 0.
- Reset mid-phase (any state) returns to these values on the next edge. No yellow is inserted on reset.
- Phase lengths in cycles:
  - Yellow: exactly SHORT_CYC.
  - All-red: exactly CLEAR_CYC.
  - Highway green: ≥ LONG_CYC.
  - Farm green: FW_MIN_CYC..LONG_CYC.
- Request latency: with car_on_fw high at the edge where timer == LONG_CYC-1 in HW_GREEN, hw_light is YELLOW on the next cycle.
- With no request, HW_GREEN holds indefinitely. The timer saturates, so long_timeout stays high.
- A car that arrives and departs during HW_GREEN is still served through `fw_req`.
- In FW_GREEN, car_on_fw does not set fw_req. A car that persists after FW_YELLOW re-sets fw_req from FW_YELLOW on.

## Structure
- Package `traffic_pkg` holds:
  - Lamp encoding: RED=2'd0, GREEN=2'd1, YELLOW=2'd2.
  - Phase-state enum.
  - Shared by this block and the road-lamp modules.
- One sub-module, `phase_timer`:
  - Clear input, saturating counter.
  - Compares generating short_timeout, long_timeout, clear_done and fw_min_done.
- The FSM and request latch stay in `intersection_sched`.

## Test plan
All scenarios use default parameters.
- **Reset:** reset_n=0 for 2 cycles, then 1 with car_on_fw=0 for 30 cycles → hw GREEN, fw RED throughout; long_timeout high from cycle 9 onward.
- **Short car pulse:** car_on_fw=1 for 1 cycle at cycle 3 only → fw_req=1 from cycle 4. Then:
  - HW_YELLOW cycles 10–12, all-red 13–14.
  - FW_GREEN 15–18 (FW_MIN exit), FW_YELLOW 19–21, all-red 22–23, HW_GREEN from 24.
- **Persistent car:** car_on_fw held 1 → FW_GREEN lasts exactly 10 cycles. fw_req re-asserts during FW_YELLOW and the next HW_GREEN lasts exactly 10 cycles.
- **Reset mid-phase:** assert reset_n=0 in FW_GREEN at timer 2 → next cycle hw GREEN, fw RED, fw_req 0, timer 0.
- **Safety/pulse checks:**
  - Random car_on_fw for 5000 cycles → never both lamps non-RED.
  - timer_reset pulses exactly once per observed lamp change.
  - Every yellow is 3 cycles and every all-red is 2 cycles.
- **Minimum parameters:** SHORT_CYC=1, CLEAR_CYC=1, FW_MIN_CYC=1, LONG_CYC=2 with a car pulse → single-cycle yellow and all-red phases, farm green exactly 1 cycle.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection scheduler and the road-lamp modules.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } lamp_t;

    typedef enum logic [2:0] {
        HW_GREEN    = 3'd0,
        HW_YELLOW   = 3'd1,
        CLEAR_TO_FW = 3'd2,
        FW_GREEN    = 3'd3,
        FW_YELLOW   = 3'd4,
        CLEAR_TO_HW = 3'd5
    } phase_t;

    // Saturation value of the shared phase timer: the longest phase limit minus one.
    function automatic int timer_max(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m - 1;
    endfunction

endpackage

// File: rtl/intersection_sched_if.sv
// Sensor input and lamp/status outputs of the intersection scheduler.
interface intersection_sched_if;
    import traffic_pkg::*;

    logic  car_on_fw;
    lamp_t hw_light;
    lamp_t fw_light;
    logic  short_timeout;
    logic  long_timeout;
    logic  timer_reset;
    logic  fw_req;

    modport master (
        output car_on_fw,
        input  hw_light, fw_light, short_timeout, long_timeout, timer_reset, fw_req
    );

    modport slave (
        input  car_on_fw,
        output hw_light, fw_light, short_timeout, long_timeout, timer_reset, fw_req
    );

endinterface

// File: rtl/phase_timer.sv
// Shared phase timer: clears on every phase transition, otherwise counts up and
// saturates at the longest phase limit so long_timeout stays high in an idle green.
module phase_timer
    import traffic_pkg::*;
#(
    parameter int SHORT_CYC  = 3,
    parameter int LONG_CYC   = 10,
    parameter int CLEAR_CYC  = 2,
    parameter int FW_MIN_CYC = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic short_timeout,
    output logic long_timeout,
    output logic clear_done,
    output logic fw_min_done
);

    localparam int TMAX = timer_max(LONG_CYC, SHORT_CYC, CLEAR_CYC);
    localparam int TW   = $clog2(TMAX) + 1;

    logic [TW-1:0] timer;

    // Saturating up-counter with synchronous clear.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            timer <= '0;
        end else if (timer != TW'(TMAX)) begin
            timer <= timer + TW'(1);
        end
    end

    assign short_timeout = (timer == TW'(SHORT_CYC - 1));
    assign long_timeout  = (timer == TW'(LONG_CYC - 1));
    assign clear_done    = (timer == TW'(CLEAR_CYC - 1));
    assign fw_min_done   = (timer >= TW'(FW_MIN_CYC - 1));

endmodule

// File: rtl/intersection_sched.sv
// Highway/farm-road phase scheduler. Highway is green by default; the farm road
// is served only when a car has been seen, for a bounded green window.
//
// state       | meaning
// HW_GREEN    | highway green, farm red; leaves after minimum green if a request is pending
// HW_YELLOW   | highway yellow, farm red
// CLEAR_TO_FW | all red before farm green
// FW_GREEN    | farm green, highway red; leaves when the road empties or at maximum green
// FW_YELLOW   | farm yellow, highway red
// CLEAR_TO_HW | all red before highway green; also the recovery target for bad encodings
module intersection_sched
    import traffic_pkg::*;
#(
    parameter int SHORT_CYC  = 3,
    parameter int LONG_CYC   = 10,
    parameter int CLEAR_CYC  = 2,
    parameter int FW_MIN_CYC = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    intersection_sched_if.slave  bus
);

    phase_t state;
    phase_t state_next;
    lamp_t  hw_lamp;
    lamp_t  fw_lamp;
    logic   timer_clr;
    logic   short_to;
    logic   long_to;
    logic   clear_done;
    logic   fw_min_done;
    logic   req;

    phase_timer #(
        .SHORT_CYC  (SHORT_CYC),
        .LONG_CYC   (LONG_CYC),
        .CLEAR_CYC  (CLEAR_CYC),
        .FW_MIN_CYC (FW_MIN_CYC)
    ) u_timer (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (timer_clr),
        .short_timeout (short_to),
        .long_timeout  (long_to),
        .clear_done    (clear_done),
        .fw_min_done   (fw_min_done)
    );

    // Phase state register; reset lands directly in highway green.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= HW_GREEN;
        end else begin
            state <= state_next;
        end
    end

    // Next phase and lamp decode; a taken transition also clears the timer.
    always_comb begin
        state_next = state;
        hw_lamp    = RED;
        fw_lamp    = RED;
        case (state)
            HW_GREEN: begin
                hw_lamp = GREEN;
                if (long_to && (req || bus.car_on_fw)) state_next = HW_YELLOW;
            end
            HW_YELLOW: begin
                hw_lamp = YELLOW;
                if (short_to) state_next = CLEAR_TO_FW;
            end
            CLEAR_TO_FW: begin
                if (clear_done) state_next = FW_GREEN;
            end
            FW_GREEN: begin
                fw_lamp = GREEN;
                if ((fw_min_done && !bus.car_on_fw) || long_to) state_next = FW_YELLOW;
            end
            FW_YELLOW: begin
                fw_lamp = YELLOW;
                if (short_to) state_next = CLEAR_TO_HW;
            end
            CLEAR_TO_HW: begin
                if (clear_done) state_next = HW_GREEN;
            end
            default: begin
                state_next = CLEAR_TO_HW;
            end
        endcase
        timer_clr = (state_next != state);
    end

    // Farm request latch: cars seen outside farm green are remembered until it is served.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req <= 1'b0;
        end else if (state != FW_GREEN && state_next == FW_GREEN) begin
            req <= 1'b0;
        end else if (bus.car_on_fw && state != FW_GREEN) begin
            req <= 1'b1;
        end
    end

    assign bus.hw_light      = hw_lamp;
    assign bus.fw_light      = fw_lamp;
    assign bus.short_timeout = short_to;
    assign bus.long_timeout  = long_to;
    assign bus.timer_reset   = timer_clr;
    assign bus.fw_req        = req;

endmodule

// File: tb/tb_intersection_sched.sv
// Bench for intersection_sched: a default-parameter instance (a) and a
// minimum-parameter instance (b), each checked every cycle against a phase model.
module tb_intersection_sched;
    import traffic_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    intersection_sched_if ifa ();
    intersection_sched_if ifb ();

    intersection_sched dut_a (
        .clk     (clk),
        .reset_n (rst_a),
        .bus     (ifa.slave)
    );

    intersection_sched #(
        .SHORT_CYC  (1),
        .LONG_CYC   (2),
        .CLEAR_CYC  (1),
        .FW_MIN_CYC (1)
    ) dut_b (
        .clk     (clk),
        .reset_n (rst_b),
        .bus     (ifb.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase index, cycles spent in the phase, pending request.
    localparam int PH_HG = 0, PH_HY = 1, PH_CF = 2, PH_FG = 3, PH_FY = 4, PH_CH = 5;
    int ps[2] = '{3, 1};
    int pl[2] = '{10, 2};
    int pc[2] = '{2, 1};
    int pf[2] = '{4, 1};
    int m_ph[2];
    int m_n[2];
    bit m_req[2];
    bit m_valid[2] = '{1'b0, 1'b0};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tval(input int k);
        int cap;
        cap = pl[k];
        if (ps[k] > cap) cap = ps[k];
        if (pc[k] > cap) cap = pc[k];
        cap = cap - 1;
        return (m_n[k] < cap) ? m_n[k] : cap;
    endfunction

    function automatic bit m_exit(input int k, input bit car);
        case (m_ph[k])
            PH_HG:        return (tval(k) == pl[k] - 1) && (m_req[k] || car);
            PH_HY, PH_FY: return m_n[k] == ps[k] - 1;
            PH_CF, PH_CH: return m_n[k] == pc[k] - 1;
            PH_FG:        return ((m_n[k] >= pf[k] - 1) && !car) || (m_n[k] == pl[k] - 1);
            default:      return 1'b0;
        endcase
    endfunction

    function automatic int exp_hw(input int k);
        return (m_ph[k] == PH_HG) ? 1 : (m_ph[k] == PH_HY) ? 2 : 0;
    endfunction

    function automatic int exp_fw(input int k);
        return (m_ph[k] == PH_FG) ? 1 : (m_ph[k] == PH_FY) ? 2 : 0;
    endfunction

    // Model advance on the same edge the DUT samples.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit car;
            bit rst;
            bit ex;
            car = (k == 0) ? ifa.car_on_fw : ifb.car_on_fw;
            rst = (k == 0) ? rst_a : rst_b;
            if (!rst) begin
                m_ph[k] = PH_HG;
                m_n[k] = 0;
                m_req[k] = 1'b0;
                m_valid[k] = 1'b1;
            end else if (m_valid[k]) begin
                ex = m_exit(k, car);
                if (ex && m_ph[k] == PH_CF) m_req[k] = 1'b0;
                else if (car && m_ph[k] != PH_FG) m_req[k] = 1'b1;
                if (ex) begin
                    m_ph[k] = (m_ph[k] + 1) % 6;
                    m_n[k] = 0;
                end else begin
                    m_n[k] = m_n[k] + 1;
                end
            end
        end
    end

    task automatic cmp_inst(input int k, input logic [1:0] hw, input logic [1:0] fw,
                            input logic rq, input logic st, input logic lt,
                            input logic tr, input logic car);
        string p;
        p = (k == 0) ? "a" : "b";
        chk({p, ".hw_light"}, int'(hw), exp_hw(k));
        chk({p, ".fw_light"}, int'(fw), exp_fw(k));
        chk({p, ".fw_req"}, int'(rq), int'(m_req[k]));
        chk({p, ".short_timeout"}, int'(st), int'(tval(k) == ps[k] - 1));
        chk({p, ".long_timeout"}, int'(lt), int'(tval(k) == pl[k] - 1));
        chk({p, ".timer_reset"}, int'(tr), int'(m_exit(k, car)));
        chk({p, ".safety"}, int'(hw != 2'd0 && fw != 2'd0), 0);
    endtask

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (m_valid[0])
            cmp_inst(0, ifa.hw_light, ifa.fw_light, ifa.fw_req, ifa.short_timeout,
                     ifa.long_timeout, ifa.timer_reset, ifa.car_on_fw);
        if (m_valid[1])
            cmp_inst(1, ifb.hw_light, ifb.fw_light, ifb.fw_req, ifb.short_timeout,
                     ifb.long_timeout, ifb.timer_reset, ifb.car_on_fw);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickn(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int w;
        int cnt;
        int eh;
        int ef;
        int ehb;
        int efb;

        ifa.car_on_fw = 1'b0;
        ifb.car_on_fw = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        tickn(2);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Idle highway: green throughout, long_timeout saturates high from cycle 9.
        for (int c = 0; c < 30; c++) begin
            #2;
            if (c == 0) begin
                chk("rst.fw_req", int'(ifa.fw_req), 0);
                chk("rst.short_timeout", int'(ifa.short_timeout), 0);
                chk("rst.timer_reset", int'(ifa.timer_reset), 0);
            end
            chk("idle.hw", int'(ifa.hw_light), 1);
            chk("idle.fw", int'(ifa.fw_light), 0);
            chk("idle.long_timeout", int'(ifa.long_timeout), int'(c >= 9));
            tick();
        end

        // Short car pulse (a at cycle 3, b at cycle 0) from a fresh reset.
        rst_a = 1'b0;
        rst_b = 1'b0;
        tickn(2);
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            ifa.car_on_fw = (c == 3);
            ifb.car_on_fw = (c == 0);
            #2;
            eh  = (c < 10 || c >= 24) ? 1 : (c <= 12) ? 2 : 0;
            ef  = (c >= 15 && c <= 18) ? 1 : (c >= 19 && c <= 21) ? 2 : 0;
            ehb = (c <= 1 || c >= 7) ? 1 : (c == 2) ? 2 : 0;
            efb = (c == 4) ? 1 : (c == 5) ? 2 : 0;
            chk("pulse.a.hw", int'(ifa.hw_light), eh);
            chk("pulse.a.fw", int'(ifa.fw_light), ef);
            chk("pulse.a.fw_req", int'(ifa.fw_req), int'(c >= 4 && c <= 14));
            chk("pulse.b.hw", int'(ifb.hw_light), ehb);
            chk("pulse.b.fw", int'(ifb.fw_light), efb);
            tick();
        end

        // Persistent car: farm green runs to its maximum, request re-latches in yellow.
        ifa.car_on_fw = 1'b1;
        w = 0;
        while (ifa.fw_light != GREEN && w < 100) begin tick(); w++; end
        chk("persist.wait_fw_green", int'(w < 100), 1);
        cnt = 0;
        while (ifa.fw_light == GREEN && cnt < 50) begin cnt++; tick(); end
        chk("persist.fw_green_len", cnt, 10);
        tickn(2);
        chk("persist.fw_yellow", int'(ifa.fw_light), 2);
        chk("persist.fw_req_in_yellow", int'(ifa.fw_req), 1);
        w = 0;
        while (ifa.hw_light != GREEN && w < 100) begin tick(); w++; end
        chk("persist.wait_hw_green", int'(w < 100), 1);
        cnt = 0;
        while (ifa.hw_light == GREEN && cnt < 50) begin cnt++; tick(); end
        chk("persist.hw_green_len", cnt, 10);

        // Reset in farm green at timer 2 returns straight to highway green.
        w = 0;
        while (ifa.fw_light != GREEN && w < 100) begin tick(); w++; end
        chk("midrst.wait_fw_green", int'(w < 100), 1);
        tickn(2);
        chk("midrst.short_at_t2", int'(ifa.short_timeout), 1);
        rst_a = 1'b0;
        tick();
        #2;
        chk("midrst.hw", int'(ifa.hw_light), 1);
        chk("midrst.fw", int'(ifa.fw_light), 0);
        chk("midrst.fw_req", int'(ifa.fw_req), 0);
        chk("midrst.short_timeout", int'(ifa.short_timeout), 0);
        chk("midrst.long_timeout", int'(ifa.long_timeout), 0);
        rst_a = 1'b1;
        ifa.car_on_fw = 1'b0;
        tick();

        // Random sensor traffic on both instances; the per-cycle compare does the checking.
        for (int i = 0; i < 5000; i++) begin
            ifa.car_on_fw = ($urandom_range(0, 3) == 0);
            ifb.car_on_fw = ($urandom_range(0, 1) == 1);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
